// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-subtract step per clock.
// Optional build macro MULDIV_EARLY_OUT_EN lets trivial cases bypass the iteration.
//   state  | meaning
//   IDLE   | waiting for start
//   CALC   | 32 iteration steps
//   FIX    | sign fix-up, result select, write out
//   DONE   | done pulse; may accept the next start
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] ra_q, ra_d, rb_q, rb_d;
    logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] out_q, out_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        a_signed_in, b_signed_in, na_in, nb_in;
    logic [31:0] amag_in, bmag_in;
    logic [32:0] mul_sum, div_part, div_diff;
    logic [63:0] prod_mag, prod_signed;
    logic [31:0] quo_s, rem_s, fix_res;
    logic        cap_div0, cap_ovf, cap_mulz;
    logic        early_in;

    always_comb begin
        a_signed_in = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed_in = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        na_in       = a_signed_in & ra[31];
        nb_in       = b_signed_in & rb[31];
        amag_in     = na_in ? (~ra + 32'd1) : ra;
        bmag_in     = nb_in ? (~rb + 32'd1) : rb;
`ifdef MULDIV_EARLY_OUT_EN
        early_in = (op[2] && (rb == 32'd0))
                 || (((op == 3'd4) || (op == 3'd6)) && (ra == 32'h8000_0000) && (rb == 32'hFFFF_FFFF))
                 || (!op[2] && ((ra == 32'd0) || (rb == 32'd0)));
`else
        early_in = 1'b0;
`endif
    end

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
        div_part = {hi_q, lo_q[31]};
        div_diff = div_part - {1'b0, mcand_q};
    end

    always_comb begin
        prod_mag    = {hi_q, lo_q};
        prod_signed = (neg_a_q ^ neg_b_q) ? (~prod_mag + 64'd1) : prod_mag;
        quo_s       = (neg_a_q ^ neg_b_q) ? (~lo_q + 32'd1) : lo_q;
        rem_s       = neg_a_q ? (~hi_q + 32'd1) : hi_q;
        cap_div0    = (rb_q == 32'd0);
        cap_ovf     = ((op_q == 3'd4) || (op_q == 3'd6))
                    && (ra_q == 32'h8000_0000) && (rb_q == 32'hFFFF_FFFF);
        cap_mulz    = (ra_q == 32'd0) || (rb_q == 32'd0);
        fix_res     = '0;
        // op[1] selects remainder for divides; special cases override the iterated value
        if (op_q[2]) begin
            if (cap_div0)      fix_res = op_q[1] ? ra_q : 32'hFFFF_FFFF;
            else if (cap_ovf)  fix_res = op_q[1] ? 32'd0 : 32'h8000_0000;
            else               fix_res = op_q[1] ? rem_s : quo_s;
        end else if (cap_mulz) begin
            fix_res = '0;
        end else if (op_q[1:0] == 2'd0) begin
            fix_res = prod_signed[31:0];
        end else begin
            fix_res = prod_signed[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        out_d   = out_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d    = op;
                    ra_d    = ra;
                    rb_d    = rb;
                    neg_a_d = na_in;
                    neg_b_d = nb_in;
                    cnt_d   = 5'd0;
                    hi_d    = 32'd0;
                    mcand_d = op[2] ? bmag_in : amag_in;
                    lo_d    = op[2] ? amag_in : bmag_in;
                    state_d = early_in ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[32]) begin
                        hi_d = div_diff[31:0];
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = div_part[31:0];
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[32:1];
                    lo_d = {mul_sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                out_d   = fix_res;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: doc/muldiv.md
# muldiv

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. Takes the same `ra`/`rb` operands and returns a 32-bit result, which the execute result mux selects in place of `alu_out` for M-extension instructions. The unit is multi-cycle: it runs one shift-add or restoring-subtract step per clock and stalls the pipeline through `busy`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new operation; sampled only when `busy`=0.
- `op` input 3: RV32M funct3 encoding.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `ra` input 32: rs1 operand (multiplicand / dividend); captured at start.
- `rb` input 32: rs2 operand (multiplier / divisor); captured at start.
- `busy` output 1: operation in flight; pipeline stalls while high.
- `done` output 1: one-cycle pulse; `out` is valid in the same cycle.
- `out` output 32: result register; holds its value until the next result is written.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: iterate.
  - FIX: sign correction and hi/lo or quotient/remainder select; writes `out`.
  - DONE: pulse `done`.
- IDLE or DONE with `start`=1 → capture `op`, `ra`, `rb` → CALC, step counter = 0.
- IDLE or DONE with `start`=0 → IDLE.
- CALC runs exactly 32 steps, then → FIX. FIX → DONE. DONE → IDLE, or → CALC if `start`=1.
- `start` while `busy`=1 is ignored; the captured operands stay unchanged.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: `ra` signed, `rb` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Signed operands are converted to magnitudes before CALC. The sign is reapplied in FIX.
- Multiply: 64-bit product. MUL returns bits [31:0]. MULH, MULHSU, MULHU return bits [63:32].
- Divide: restoring, unsigned magnitude.
  - Quotient sign = sign(ra) XOR sign(rb).
  - Remainder sign = sign(ra).
- Divide-by-zero (`rb`=0):
  - DIV, DIVU → 0xFFFFFFFF.
  - REM, REMU → `ra`.
- Signed overflow (DIV/REM, `ra`=0x80000000, `rb`=0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- Reset values: state IDLE, `busy`=0, `done`=0, `out`=0, counter 0.
- Reset during CALC or FIX aborts the operation: no `done` pulse, `out` reset to 0.

## Timing
- Cycle 0: `start`=1 with `busy`=0, operands latched at the edge.
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: FIX, `busy`=1.
- Cycle 34: DONE, `done`=1, `out` valid, `busy`=0.
- Fixed latency: 34 cycles from start to `done`.
- Back-to-back: `start` in the DONE cycle begins the next operation. Its `done` arrives 34 cycles later; there are no idle bubbles.
- `busy` and `done` are never high in the same cycle.
- `busy` is registered and has no combinational path from `start`.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Applies when the captured operation is divide-by-zero, signed overflow, or a multiply with `ra`=0 or `rb`=0.
  - These cases skip CALC: cycle 1 FIX, cycle 2 DONE, with `done` at cycle 2.
  - Results are identical to the full-latency path.
- Not defined: every operation takes the full 34 cycles, and the special cases are resolved in FIX.

## Test plan
- MUL `ra`=7, `rb`=0xFFFFFFFD → `out`=0xFFFFFFEB, `done` exactly at cycle 34, `busy` high for cycles 1–33.
- Upper-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, `ra`=0xFFFFFFF9 (−7), `rb`=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Corner cases:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REMU 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
  - With `MULDIV_EARLY_OUT_EN`: all four `done` at cycle 2.
- Busy handling:
  - `start` pulsed at cycle 10 of an operation with different operands → ignored, original result delivered.
  - `start` held in the DONE cycle → second result 34 cycles later.
- Reset mid-operation: `rst` at cycle 15 → `busy`=0, `out`=0 next cycle, no `done` pulse; a following MUL 3×5 → `out`=15 at cycle 34.
